// File: rtl/interpolator.sv
`default_nettype none
// ============================================================================
//  Module      : interpolator
//  Description : Linear 2^M-times upsampler. Low-rate unsigned samples enter
//                over a valid/ready handshake. Each ena tick in RUN emits one
//                sample on the straight line from the previous to the current
//                input, taking exactly 2^M ticks per input interval. A
//                one-entry holding register (nxt) refills the segment
//                seamlessly when the current segment ends.
//  Ports       : cclk            clock, all logic on the rising edge
//                rst             asynchronous active-high reset
//                ena             high-rate output tick
//                clr             synchronous clear of the underrun status
//                in_data/in_valid/in_ready  low-rate sample handshake
//                out_data        interpolated sample (registered)
//                out_valid       one-cycle pulse, cycle after a productive ena
//                underrun        sticky: segment ended with nothing buffered
//                underrun_count  (INTERP_UNDERRUN_CNT_EN only) saturating
//                                16-bit count of underrun events
//  Options     : INTERP_UNDERRUN_CNT_EN adds the underrun_count port/counter.
//  Revision    : 1.0  initial release
// ============================================================================
module interpolator #(
    parameter int N = 8,
    parameter int M = 2
) (
    input  logic         cclk,
    input  logic         rst,
    input  logic         ena,
    input  logic         clr,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    output logic         underrun
`ifdef INTERP_UNDERRUN_CNT_EN
    ,
    output logic [15:0]  underrun_count
`endif
);

    localparam int            c_AW         = N + M + 1;
    localparam logic [M-1:0]  c_PHASE_LAST = '1;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_PRIMED = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t            r_state,     w_state;
    logic [N-1:0]      r_prev,      w_prev;
    logic [N-1:0]      r_cur,       w_cur;
    logic [N-1:0]      r_nxt,       w_nxt;
    logic              r_nxt_full,  w_nxt_full;
    logic [c_AW-1:0]   r_acc,       w_acc;
    logic [N:0]        r_step,      w_step;
    logic [M-1:0]      r_phase,     w_phase;
    logic [N-1:0]      r_out_data,  w_out_data;
    logic              r_out_valid, w_out_valid;
    logic              r_underrun,  w_underrun;
    logic              w_xfer;
    logic              w_set_underrun;
    logic [N-1:0]      w_sample;

    // Ready depends on registers only, so it never loops back through in_valid.
    assign in_ready  = (r_state != S_RUN) | ~r_nxt_full;
    assign w_xfer    = in_valid & in_ready;

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign underrun  = r_underrun;

    always_comb begin
        w_state        = r_state;
        w_prev         = r_prev;
        w_cur          = r_cur;
        w_nxt          = r_nxt;
        w_nxt_full     = r_nxt_full;
        w_acc          = r_acc;
        w_step         = r_step;
        w_phase        = r_phase;
        w_out_data     = r_out_data;
        w_out_valid    = 1'b0;
        w_set_underrun = 1'b0;
        w_sample       = r_nxt_full ? r_nxt : in_data;

        case (r_state)
            S_EMPTY: begin
                if (w_xfer) begin
                    w_prev  = in_data;
                    w_state = S_PRIMED;
                end
            end
            S_PRIMED: begin
                if (w_xfer) begin
                    w_cur   = in_data;
                    w_step  = {1'b0, in_data} - {1'b0, r_prev};
                    w_acc   = {1'b0, r_prev, {M{1'b0}}};
                    w_phase = '0;
                    w_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_xfer) begin
                    w_nxt      = in_data;
                    w_nxt_full = 1'b1;
                end
                if (ena) begin
                    // acc holds the line value scaled by 2^M; its integer
                    // part is the floor of the interpolated sample.
                    w_out_data  = r_acc[N+M-1:M];
                    w_out_valid = 1'b1;
                    w_acc       = r_acc + {{M{r_step[N]}}, r_step};
                    w_phase     = r_phase + M'(1);
                    if (r_phase == c_PHASE_LAST) begin
                        w_prev = r_cur;
                        // A sample arriving on the very last tick is taken
                        // straight into the next segment instead of nxt.
                        if (r_nxt_full || w_xfer) begin
                            w_cur      = w_sample;
                            w_step     = {1'b0, w_sample} - {1'b0, r_cur};
                            w_acc      = {1'b0, r_cur, {M{1'b0}}};
                            w_nxt_full = 1'b0;
                        end else begin
                            w_set_underrun = 1'b1;
                            w_state        = S_PRIMED;
                        end
                    end
                end
            end
            default: begin
                w_state = S_EMPTY;
            end
        endcase

        w_underrun = r_underrun | w_set_underrun;
        if (clr) begin
            w_underrun = 1'b0;
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_prev      <= '0;
            r_cur       <= '0;
            r_nxt       <= '0;
            r_nxt_full  <= 1'b0;
            r_acc       <= '0;
            r_step      <= '0;
            r_phase     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_prev      <= w_prev;
            r_cur       <= w_cur;
            r_nxt       <= w_nxt;
            r_nxt_full  <= w_nxt_full;
            r_acc       <= w_acc;
            r_step      <= w_step;
            r_phase     <= w_phase;
            r_out_data  <= w_out_data;
            r_out_valid <= w_out_valid;
            r_underrun  <= w_underrun;
        end
    end

`ifdef INTERP_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_count;
    logic [15:0] w_underrun_count;

    always_comb begin
        w_underrun_count = r_underrun_count;
        if (w_set_underrun && (r_underrun_count != 16'hFFFF)) begin
            w_underrun_count = r_underrun_count + 16'd1;
        end
        if (clr) begin
            w_underrun_count = 16'd0;
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            r_underrun_count <= 16'd0;
        end else begin
            r_underrun_count <= w_underrun_count;
        end
    end

    assign underrun_count = r_underrun_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_interpolator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interpolator
//  Description : Self-checking bench for interpolator (N=8, M=2). Directed
//                scenarios plus a randomized run scored against a reference
//                model: the output stream is the concatenation of straight
//                line segments between consecutive accepted samples.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_interpolator;

    localparam int N     = 8;
    localparam int M     = 2;
    localparam int RATIO = 1 << M;

    logic         cclk = 1'b0;
    logic         rst;
    logic         ena;
    logic         clr;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         underrun;
`ifdef INTERP_UNDERRUN_CNT_EN
    logic [15:0]  underrun_count;
`endif

    int checks = 0;
    int errors = 0;

    interpolator #(.N(N), .M(M)) dut (
        .cclk           (cclk),
        .rst            (rst),
        .ena            (ena),
        .clr            (clr),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .underrun       (underrun)
`ifdef INTERP_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 cclk = ~cclk;

    // k-th sample of the line from a to b (k = 0 .. RATIO-1), floored.
    // The numerator is never negative, so integer division is a floor.
    function automatic int interp(input int a, input int b, input int k);
        return (a * RATIO + k * (b - a)) / RATIO;
    endfunction

    // One clock: drive at the falling edge, return at the next falling edge
    // with the registered results of that rising edge visible.
    task automatic tick(input bit v, input logic [N-1:0] d, input bit e, output bit took);
        in_valid = v;
        in_data  = d;
        ena      = e;
        #1;
        took = v && in_ready;
        @(posedge cclk);
        @(negedge cclk);
        in_valid = 1'b0;
        ena      = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic feed(input logic [N-1:0] d);
        bit took;
        tick(1'b1, d, 1'b0, took);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge cclk);
        @(negedge cclk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge cclk);
        @(negedge cclk);
        checks++; if (out_data !== 8'd0)  begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (underrun !== 1'b0)  begin errors++; $display("FAIL reset_underrun: got %0b expected 0", underrun); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        rst = 1'b0;
        @(negedge cclk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_reset_in_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_ramp();
        int  exp_v[8] = '{0, 25, 50, 75, 100, 125, 150, 175};
        bit  took;
        do_reset();
        feed(8'd0); feed(8'd100); feed(8'd200);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                checks++;
                if (underrun !== 1'b0) begin errors++; $display("FAIL ramp_no_underrun: got %0b expected 0", underrun); end
            end
            tick(1'b0, 8'd0, 1'b1, took);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_v[k]) begin
                errors++;
                $display("FAIL ramp[%0d]: got valid=%0b data=%0d expected valid=1 data=%0d", k, out_valid, out_data, exp_v[k]);
            end
        end
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL ramp_end_underrun: got %0b expected 1", underrun); end
    endtask

    task automatic test_descend();
        int  exp_v[4] = '{200, 150, 100, 50};
        bit  took;
        do_reset();
        feed(8'd200); feed(8'd0);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 8'd0, 1'b1, took);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_v[k]) begin
                errors++;
                $display("FAIL descend[%0d]: got valid=%0b data=%0d expected valid=1 data=%0d", k, out_valid, out_data, exp_v[k]);
            end
        end
    endtask

    task automatic test_underrun();
        int  exp_a[4] = '{0, 25, 50, 75};
        int  exp_b[4] = '{100, 85, 70, 55};
        bit  took;
        do_reset();
        feed(8'd0); feed(8'd100);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 8'd0, 1'b1, took);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_a[k]) begin
                errors++;
                $display("FAIL underrun_a[%0d]: got valid=%0b data=%0d expected valid=1 data=%0d", k, out_valid, out_data, exp_a[k]);
            end
        end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %0b expected 1", underrun); end
        tick(1'b0, 8'd0, 1'b1, took);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL underrun_idle_ena: got valid=%0b expected 0", out_valid); end
        checks++; if (out_data !== 8'd75) begin errors++; $display("FAIL underrun_hold: got %0d expected 75", out_data); end
        feed(8'd40);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 8'd0, 1'b1, took);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_b[k]) begin
                errors++;
                $display("FAIL underrun_b[%0d]: got valid=%0b data=%0d expected valid=1 data=%0d", k, out_valid, out_data, exp_b[k]);
            end
        end
        clr = 1'b1;
        tick(1'b0, 8'd0, 1'b0, took);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clr: got %0b expected 0", underrun); end
        // clr in the same cycle as an underrun-producing last step must win
        do_reset();
        feed(8'd0); feed(8'd4);
        for (int k = 0; k < 3; k++) tick(1'b0, 8'd0, 1'b1, took);
        clr = 1'b1;
        tick(1'b0, 8'd0, 1'b1, took);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL clr_wins: got %0b expected 0", underrun); end
    endtask

    task automatic test_back_to_back();
        int  exp_v[12];
        int  pts[4] = '{10, 50, 90, 130};
        bit  took;
        bit  accepted;
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < RATIO; k++)
                exp_v[s*RATIO + k] = interp(pts[s], pts[s+1], k);
        do_reset();
        feed(8'd10); feed(8'd50); feed(8'd90);
        accepted = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick(!accepted, 8'd130, 1'b1, took);
            if (k < 5) begin
                checks++;
                if (took !== (k == 4)) begin
                    errors++;
                    $display("FAIL hold_accept[%0d]: got %0b expected %0b", k, took, (k == 4));
                end
            end
            if (took) accepted = 1'b1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_v[k]) begin
                errors++;
                $display("FAIL b2b[%0d]: got valid=%0b data=%0d expected valid=1 data=%0d", k, out_valid, out_data, exp_v[k]);
            end
        end
        // sample arriving exactly on the last step with nxt empty
        do_reset();
        feed(8'd0); feed(8'd40);
        for (int k = 0; k < 3; k++) tick(1'b0, 8'd0, 1'b1, took);
        tick(1'b1, 8'd80, 1'b1, took);
        checks++; if (took !== 1'b1) begin errors++; $display("FAIL direct_accept: got %0b expected 1", took); end
        checks++; if (out_data !== 8'd30 || underrun !== 1'b0) begin
            errors++; $display("FAIL direct_step: got data=%0d underrun=%0b expected data=30 underrun=0", out_data, underrun);
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 8'd0, 1'b1, took);
            checks++;
            if (out_valid !== 1'b1 || out_data !== interp(40, 80, k)) begin
                errors++;
                $display("FAIL direct[%0d]: got valid=%0b data=%0d expected valid=1 data=%0d", k, out_valid, out_data, interp(40, 80, k));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit took;
        do_reset();
        feed(8'd0); feed(8'd100);
        tick(1'b0, 8'd0, 1'b1, took);
        tick(1'b0, 8'd0, 1'b1, took);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_data !== 8'd0 || out_valid !== 1'b0 || underrun !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got data=%0d valid=%0b underrun=%0b ready=%0b expected 0/0/0/1",
                     out_data, out_valid, underrun, in_ready);
        end
        @(negedge cclk);
        rst = 1'b0;
        feed(8'd7);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 8'd0, 1'b1, took);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_first_sample[%0d]: got valid=%0b expected 0", k, out_valid); end
        end
        feed(8'd9);
        tick(1'b0, 8'd0, 1'b1, took);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd7) begin
            errors++; $display("FAIL reset_restart: got valid=%0b data=%0d expected valid=1 data=7", out_valid, out_data);
        end
    endtask

    task automatic test_random();
        int  expq[$];
        int  last;
        bit  have_prev;
        bit  took;
        bit  v;
        bit  e;
        logic [N-1:0] d;
        int  exp_d;
        do_reset();
        have_prev = 1'b0;
        last      = 0;
        for (int c = 0; c < 620; c++) begin
            v = (c < 600) && ($urandom_range(0, 99) < 35);
            e = (c >= 600) || ($urandom_range(0, 99) < 75);
            d = N'($urandom_range(0, 255));
            tick(v, d, e, took);
            if (took) begin
                if (have_prev)
                    for (int k = 0; k < RATIO; k++) expq.push_back(interp(last, int'(d), k));
                last      = int'(d);
                have_prev = 1'b1;
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL random_extra[%0d]: got data=%0d expected no output", c, out_data);
                end else begin
                    exp_d = expq.pop_front();
                    if (out_data !== exp_d) begin
                        errors++;
                        $display("FAIL random[%0d]: got %0d expected %0d", c, out_data, exp_d);
                    end
                end
            end
        end
        checks++;
        if (expq.size() != 0) begin
            errors++; $display("FAIL random_drain: got %0d outputs pending expected 0", expq.size());
        end
    endtask

`ifdef INTERP_UNDERRUN_CNT_EN
    task automatic test_counter();
        bit took;
        do_reset();
        feed(8'd0);
        for (int u = 0; u < 3; u++) begin
            feed(N'(10 * (u + 1)));
            for (int k = 0; k < 4; k++) tick(1'b0, 8'd0, 1'b1, took);
        end
        checks++; if (underrun_count !== 16'd3) begin errors++; $display("FAIL count3: got %0d expected 3", underrun_count); end
        clr = 1'b1;
        tick(1'b0, 8'd0, 1'b0, took);
        checks++; if (underrun_count !== 16'd0 || underrun !== 1'b0) begin
            errors++; $display("FAIL count_clr: got count=%0d underrun=%0b expected 0/0", underrun_count, underrun);
        end
        force dut.r_underrun_count = 16'hFFFE;
        @(negedge cclk);
        release dut.r_underrun_count;
        for (int u = 0; u < 2; u++) begin
            feed(N'(50 + u));
            for (int k = 0; k < 4; k++) tick(1'b0, 8'd0, 1'b1, took);
        end
        checks++; if (underrun_count !== 16'hFFFF) begin errors++; $display("FAIL count_sat: got %0h expected ffff", underrun_count); end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        ena      = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge cclk);
        test_reset();
        test_ramp();
        test_descend();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef INTERP_UNDERRUN_CNT_EN
        test_counter();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
